scan_decoder: RTL and testbench
===============================

// Module: scan_decoder
// PURPOSE
//  Registered, parametrised N-to-2^N one-hot decoder with enable and an
//  auto-scan mode. In DIRECT mode it decodes a select input (like the
//  combinational 3-to-8 decoder). In SCAN mode it steps its own index through
//  every output, holding each one for a programmable dwell. Used for display
//  digit multiplexing, row strobing and round-robin channel select.
// PARAMETERS
//  SEL_W      3  select width; output count NOUT = 2**SEL_W
//  DWELL_W    8  dwell-count width; each index is held dwell+1 cycles
//  ACTIVE_LOW 0  1: q outputs are active-low (inverted at the output register)
// PORTS
//  clk    in   1        clock; all logic is on the rising edge
//  rst    in   1        synchronous reset, active-high
//  e      in   1        enable; 0 forces every q output inactive
//  mode   in   1        0 = DIRECT, 1 = SCAN
//  s      in   SEL_W    DIRECT: index to decode; SCAN: start index on load
//  load   in   1        SCAN: jump to index s (single-cycle strobe)
//  dwell  in   DWELL_W  cycles per index minus 1 (SCAN only)
//  q      out  NOUT     one-hot decoded output, polarity set by ACTIVE_LOW
//  idx    out  SEL_W    index currently driven on q
//  wrap   out  1        1-cycle pulse when the scan advances NOUT-1 -> 0
// BEHAVIOUR
//  - Reset (rst=1 at an edge): state=IDLE, idx=0, dwell counter=0, wrap=0.
//    q is all-inactive: all 0, or all 1 if ACTIVE_LOW. rst overrides every
//    other input.
//  - States: IDLE (e=0), DIRECT (e=1, mode=0), SCAN (e=1, mode=1).
//    The next state is evaluated every cycle from e and mode; e=0 wins.
//  - Outputs are registered. q is always decode(idx), or all-inactive in IDLE.
//  - DIRECT: idx<=s each cycle, so q reflects s one clock later (latency 1).
//    load and dwell are ignored. wrap=0.
//  - SCAN: a counter cnt counts 0..dwell. When cnt==dwell, idx<=idx+1
//    (mod NOUT) and cnt<=0. Otherwise cnt<=cnt+1.
//    - wrap=1 for exactly the cycle in which idx holds 0 after advancing from
//      NOUT-1. It is not asserted on load, on entry, or on reset to 0.
//    - dwell=0 advances idx every cycle.
//    - dwell is sampled on every compare, so a change takes effect at once.
//      If the new dwell is below the current cnt, the index advances on the
//      next cnt==dwell after the counter wraps. Drivers must only change
//      dwell at an index boundary.
//  - load in SCAN: idx<=s and cnt<=0 on the next edge. load has priority over
//    an advance in the same cycle, and no wrap is produced.
//  - Entering SCAN from DIRECT or IDLE: cnt<=0. idx keeps its value, so the
//    scan resumes from the last index (plus load if asserted in that cycle).
//  - Entering IDLE (e=0): q is inactive the next cycle. idx and cnt are held
//    frozen, and wrap=0.
//  - Leaving SCAN for DIRECT: idx<=s next cycle and cnt is cleared.
//  - idx and cnt arithmetic is unsigned and wraps modulo 2**width.
//    There is no X propagation from an unused s while in SCAN.
// TESTING
//  1. Reset, SEL_W=3, e=1, mode=0, s=0..7 one per cycle -> q=8'b1<<s one
//     cycle later, idx==s, wrap=0.
//  2. e=0 mid-DIRECT with s=5 -> q=8'h00 next cycle and idx stays 5.
//     With ACTIVE_LOW=1 -> q=8'hFF.
//  3. SCAN, dwell=2, from idx=0 -> each q bit is high for 3 cycles, in order
//     0..7. wrap=1 for one cycle when idx returns to 0 (24 cycles per lap).
//  4. SCAN, dwell=0 -> idx increments every cycle and wrap pulses every 8
//     cycles. load with s=6 while cnt==dwell -> idx=6 next cycle, no wrap.
//  5. rst asserted mid-scan at idx=4 -> next cycle q=0, idx=0, wrap=0, IDLE.
//     Releasing with e=1, mode=1 restarts the scan from 0.
//  6. e=0 for 5 cycles during SCAN at idx=3 -> q inactive. Re-enable -> idx=3
//     with a full dwell before advancing. Then mode=0, s=1 -> q=8'h02 next
//     cycle.

Source files
------------

// File: rtl/scan_decoder.sv
// scan_decoder: registered one-hot decoder with direct select and auto-scan modes
module scan_decoder #(
    parameter int SEL_W      = 3,
    parameter int DWELL_W    = 8,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  e,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      s,
    input  logic                  load,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [(2**SEL_W)-1:0] q,
    output logic [SEL_W-1:0]      idx,
    output logic                  wrap
);
    localparam int NOUT = 2**SEL_W;
    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
    state_t st, nst;
    logic [DWELL_W-1:0] cnt, ncnt;
    logic [SEL_W-1:0] nidx;
    logic nwrap;
    logic [NOUT-1:0] dec, nq;
    // next state from e/mode, then next index, dwell counter, wrap and decoded q
    always_comb begin
        nst = !e ? IDLE : (mode ? SCAN : DIRECT);
        nidx = idx;
        ncnt = cnt;
        nwrap = 1'b0;
        if (nst == DIRECT) begin
            nidx = s;
            ncnt = '0;
        end else if (nst == SCAN) begin
            if (load) begin
                nidx = s;
                ncnt = '0;
            end else if (st != SCAN) begin
                ncnt = '0;
            end else if (cnt == dwell) begin
                nidx = idx + 1'b1;
                ncnt = '0;
                nwrap = &idx;
            end else begin
                ncnt = cnt + 1'b1;
            end
        end
        dec = (nst == IDLE) ? '0 : ({{(NOUT-1){1'b0}}, 1'b1} << nidx);
        nq = (ACTIVE_LOW != 0) ? ~dec : dec;
    end
    // state and output registers; reset leaves q inactive at its configured polarity
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= IDLE;
            idx <= '0;
            cnt <= '0;
            wrap <= 1'b0;
            q <= (ACTIVE_LOW != 0) ? '1 : '0;
        end else begin
            st <= nst;
            idx <= nidx;
            cnt <= ncnt;
            wrap <= nwrap;
            q <= nq;
        end
    end
endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: vector table plus scan sequences, checking active-high and active-low instances
module tb_scan_decoder;
    logic clk = 1'b0;
    logic rst, e, mode, load;
    logic [2:0] s;
    logic [7:0] dwell;
    logic [7:0] q, qn;
    logic [2:0] idx, idxn;
    logic wrap, wrapn;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic rst, e, mode, load;
        logic [2:0] s;
        logic [7:0] dwell;
        logic [7:0] q;
        logic [2:0] idx;
        logic wrap;
    } vec_t;
    typedef struct {
        string nm;
        logic [7:0] q;
        logic [2:0] idx;
        logic wrap;
    } exp_t;
    exp_t sb[$];
    vec_t tbl[14];

    always #5 clk = ~clk;

    scan_decoder #(.SEL_W(3), .DWELL_W(8), .ACTIVE_LOW(0)) u_hi (
        .clk(clk), .rst(rst), .e(e), .mode(mode), .s(s), .load(load),
        .dwell(dwell), .q(q), .idx(idx), .wrap(wrap));
    scan_decoder #(.SEL_W(3), .DWELL_W(8), .ACTIVE_LOW(1)) u_lo (
        .clk(clk), .rst(rst), .e(e), .mode(mode), .s(s), .load(load),
        .dwell(dwell), .q(qn), .idx(idxn), .wrap(wrapn));

    function automatic logic [7:0] dec(input logic [2:0] i);
        logic [7:0] one;
        one = 8'd1;
        return one << i;
    endfunction

    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", nm, act, req);
        end
    endtask

    task automatic drive(input logic r, input logic en, input logic m, input logic ld,
                         input logic [2:0] sv, input logic [7:0] dw);
        rst = r; e = en; mode = m; load = ld; s = sv; dwell = dw;
    endtask

    task automatic step(input string nm, input logic [7:0] eq, input logic [2:0] ei, input logic ew);
        exp_t x;
        sb.push_back('{nm, eq, ei, ew});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        cmp({x.nm, " q"}, q, x.q);
        cmp({x.nm, " q_low"}, qn, ~x.q);
        cmp({x.nm, " idx"}, {5'd0, idx}, {5'd0, x.idx});
        cmp({x.nm, " idx_low"}, {5'd0, idxn}, {5'd0, x.idx});
        cmp({x.nm, " wrap"}, {7'd0, wrap}, {7'd0, x.wrap});
        cmp({x.nm, " wrap_low"}, {7'd0, wrapn}, {7'd0, x.wrap});
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 8'h00, 3'd0, 1'b0};
        for (int i = 0; i < 8; i++)
            tbl[i+1] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'(i), 8'd0, dec(3'(i)), 3'(i), 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 8'd0, 8'h20, 3'd5, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 8'd0, 8'h00, 3'd5, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd6, 8'd1, 8'h00, 3'd5, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 8'd7, 8'h08, 3'd3, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 8'h01, 3'd0, 1'b0};
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].rst, tbl[i].e, tbl[i].mode, tbl[i].load, tbl[i].s, tbl[i].dwell);
            step($sformatf("vec%0d", i), tbl[i].q, tbl[i].idx, tbl[i].wrap);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'd2);
        for (int k = 0; k < 50; k++)
            step($sformatf("scan3 k%0d", k), dec(3'((k / 3) % 8)), 3'((k / 3) % 8), k > 0 && k % 24 == 0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 8'd0);
        step("rst0", 8'h00, 3'd0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'd0);
        for (int k = 0; k < 24; k++)
            step($sformatf("scan1 k%0d", k), dec(3'(k % 8)), 3'(k % 8), k > 0 && k % 8 == 0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 3'd6, 8'd0);
        step("load6", dec(3'd6), 3'd6, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'd0);
        step("after_load7", dec(3'd7), 3'd7, 1'b0);
        step("after_load0", dec(3'd0), 3'd0, 1'b1);
        for (int k = 1; k <= 4; k++)
            step($sformatf("pre_rst %0d", k), dec(3'(k)), 3'(k), 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 8'd0);
        step("rst_mid", 8'h00, 3'd0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'd0);
        for (int k = 0; k < 3; k++)
            step($sformatf("restart %0d", k), dec(3'(k)), 3'(k), 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 8'd2);
        step("load3", dec(3'd3), 3'd3, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'd2);
        for (int k = 0; k < 5; k++)
            step($sformatf("idle %0d", k), 8'h00, 3'd3, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'd2);
        for (int k = 0; k < 4; k++)
            step($sformatf("resume %0d", k), dec(k < 3 ? 3'd3 : 3'd4), k < 3 ? 3'd3 : 3'd4, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 8'd2);
        step("direct1", 8'h02, 3'd1, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
